comparator_sweep: RTL

Self-checking stimulus engine for the 4-bit magnitude comparator. It drives operand pairs onto the comparator's A/B inputs and samples its 3-bit result P after a settle window. It checks P against an internally computed expectation and reports an error count plus the first failing pair. It sits on the opposite side of the comparator interface, as the on-chip driver and checker replacing a simulation-only sweep.

---
 rtl/comparator_sweep.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/comparator_sweep.sv
// ---------------------------------------------------------------------------
// comparator_sweep
//
// On-chip stimulus engine and checker for a WIDTH-bit magnitude comparator.
// Walks every operand pair (A, B) with A and B in 0..LIMIT-1, B fastest.
// Each pair is driven, left to settle for SETTLE cycles and then checked
// against the ideal comparator result. The block reports a saturating
// mismatch count and the first pair that failed.
//
// Parameters
//   WIDTH   operand width, matches the comparator A/B ports
//   LIMIT   sweep bound, 2 <= LIMIT <= 2**WIDTH
//   SETTLE  cycles spent waiting between driving a pair and sampling P (>= 1)
//
// Ports
//   clk                              single rising-edge clock
//   reset                            asynchronous, active-high reset
//   comparator_sweep_port_start      one-cycle start request (IDLE/DONE only)
//   comparator_sweep_port_P          comparator result {gt, eq, lt}
//   comparator_sweep_oport_A/B       registered operands to the comparator
//   comparator_sweep_oport_busy      sweep in progress
//   comparator_sweep_oport_done      sweep complete, held until next start
//   comparator_sweep_oport_pass      with done: no mismatches were seen
//   comparator_sweep_oport_err_count mismatch count, saturates at 255
//   comparator_sweep_oport_fail_A/B  first mismatching pair, 0 if none
// ---------------------------------------------------------------------------
module comparator_sweep #(
   parameter int WIDTH  = 4,
   parameter int LIMIT  = 10,
   parameter int SETTLE = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             comparator_sweep_port_start,
   input  logic [2:0]       comparator_sweep_port_P,
   output logic [WIDTH-1:0] comparator_sweep_oport_A,
   output logic [WIDTH-1:0] comparator_sweep_oport_B,
   output logic             comparator_sweep_oport_busy,
   output logic             comparator_sweep_oport_done,
   output logic             comparator_sweep_oport_pass,
   output logic [7:0]       comparator_sweep_oport_err_count,
   output logic [WIDTH-1:0] comparator_sweep_oport_fail_A,
   output logic [WIDTH-1:0] comparator_sweep_oport_fail_B
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DRIVE  = 3'd1;
   localparam logic [2:0] ST_SETTLE = 3'd2;
   localparam logic [2:0] ST_CHECK  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   // The settle counter only ever holds SETTLE-1 down to 0.
   localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
   localparam logic [WIDTH-1:0] LAST        = WIDTH'(LIMIT - 1);

   logic [2:0]       state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CNT_W-1:0] settle_cnt;
   logic [7:0]       err_q;
   logic [WIDTH-1:0] fail_a_q;
   logic [WIDTH-1:0] fail_b_q;
   logic             first_seen;
   logic [2:0]       expected_p;
   logic             mismatch;

   // Ideal comparator result for the pair currently on the outputs.
   // Anything other than this exact one-hot code counts as a mismatch,
   // so stuck-at-zero or multi-hot results are caught as well.
   always_comb begin
      expected_p = 3'b001;
      if (a_q > b_q) begin
         expected_p = 3'b100;
      end else if (a_q == b_q) begin
         expected_p = 3'b010;
      end
      mismatch = (comparator_sweep_port_P != expected_p);
   end

   // Sweep sequencer. A pair costs one DRIVE cycle, SETTLE cycles of waiting
   // and one CHECK cycle. Start is only honoured from IDLE or DONE, so a
   // start landing on the final CHECK edge is dropped and DONE is entered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         a_q        <= '0;
         b_q        <= '0;
         settle_cnt <= '0;
         err_q      <= '0;
         fail_a_q   <= '0;
         fail_b_q   <= '0;
         first_seen <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (comparator_sweep_port_start) begin
                  state      <= ST_DRIVE;
                  a_q        <= '0;
                  b_q        <= '0;
                  err_q      <= '0;
                  fail_a_q   <= '0;
                  fail_b_q   <= '0;
                  first_seen <= 1'b0;
               end
            end
            ST_DRIVE: begin
               settle_cnt <= SETTLE_LOAD;
               state      <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  if (err_q != 8'hFF) begin
                     err_q <= err_q + 8'd1;
                  end
                  if (!first_seen) begin
                     fail_a_q   <= a_q;
                     fail_b_q   <= b_q;
                     first_seen <= 1'b1;
                  end
               end
               if (b_q < LAST) begin
                  b_q   <= b_q + 1'b1;
                  state <= ST_DRIVE;
               end else if (a_q < LAST) begin
                  b_q   <= '0;
                  a_q   <= a_q + 1'b1;
                  state <= ST_DRIVE;
               end else begin
                  state <= ST_DONE;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign comparator_sweep_oport_A         = a_q;
   assign comparator_sweep_oport_B         = b_q;
   assign comparator_sweep_oport_busy      = (state == ST_DRIVE) || (state == ST_SETTLE) ||
                                             (state == ST_CHECK);
   assign comparator_sweep_oport_done      = (state == ST_DONE);
   assign comparator_sweep_oport_pass      = (state == ST_DONE) && (err_q == 8'd0);
   assign comparator_sweep_oport_err_count = err_q;
   assign comparator_sweep_oport_fail_A    = fail_a_q;
   assign comparator_sweep_oport_fail_B    = fail_b_q;

endmodule
